// File: rtl/iob_cache_write_buffer.sv
// Write-through FIFO feeding the AXI write channel; the issue registers hold the last popped entry stable.
// Optional same-address merge into the newest entry when IOB_CACHE_WBUF_MERGE_EN is defined.
`timescale 1ns/1ps
module iob_cache_write_buffer #(
  parameter int ADDR_W      = 24,
  parameter int DATA_W      = 32,
  parameter int DEPTH_W     = 2,
  parameter int FE_NBYTES   = DATA_W/8,
  parameter int FE_NBYTES_W = $clog2(FE_NBYTES)
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic                          push_i,
  input  logic [ADDR_W-FE_NBYTES_W-1:0] push_addr_i,
  input  logic [DATA_W-1:0]             push_wdata_i,
  input  logic [FE_NBYTES-1:0]          push_wstrb_i,
  output logic                          full_o,
  output logic                          empty_o,
  output logic [DEPTH_W:0]              level_o,
  output logic                          valid_o,
  input  logic                          ready_i,
  output logic [ADDR_W-FE_NBYTES_W-1:0] addr_o,
  output logic [DATA_W-1:0]             wdata_o,
  output logic [FE_NBYTES-1:0]          wstrb_o
);
  localparam int DEPTH = 1 << DEPTH_W;
  localparam int AW    = ADDR_W - FE_NBYTES_W;

  logic [AW-1:0]        r_mem_addr [DEPTH];
  logic [DATA_W-1:0]    r_mem_data [DEPTH];
  logic [FE_NBYTES-1:0] r_mem_strb [DEPTH];

  logic [DEPTH_W-1:0]   r_rd_ptr;
  logic [DEPTH_W-1:0]   r_wr_ptr;
  logic [DEPTH_W:0]     r_count;
  logic [AW-1:0]        r_addr;
  logic [DATA_W-1:0]    r_wdata;
  logic [FE_NBYTES-1:0] r_wstrb;
  logic                 r_busy;

  logic                 w_pop;
  logic                 w_full;
  logic                 w_alloc;
  logic                 w_merge;
  logic [DEPTH_W-1:0]   w_last_ptr;

  // count never exceeds DEPTH, so its MSB alone marks full
  assign w_full     = r_count[DEPTH_W];
  assign valid_o    = (r_count != '0);
  assign w_pop      = valid_o & ready_i;
  assign w_last_ptr = r_wr_ptr - DEPTH_W'(1);

`ifdef IOB_CACHE_WBUF_MERGE_EN
  // newest entry is leaving when it is the only one and is popped now
  assign w_merge = push_i & (r_count != '0)
                 & ~((r_count == (DEPTH_W+1)'(1)) & w_pop)
                 & (r_mem_addr[w_last_ptr] == push_addr_i);
  assign w_alloc = push_i & (~w_full | w_pop) & ~w_merge;
`else
  assign w_merge = 1'b0;
  assign w_alloc = push_i & (~w_full | w_pop);
`endif

  always_ff @(posedge clk_i) begin
    if (w_alloc) begin
      r_mem_addr[r_wr_ptr] <= push_addr_i;
      r_mem_data[r_wr_ptr] <= push_wdata_i;
      r_mem_strb[r_wr_ptr] <= push_wstrb_i;
    end else if (w_merge) begin
      for (int b = 0; b < FE_NBYTES; b++) begin
        if (push_wstrb_i[b]) begin
          r_mem_data[w_last_ptr][b*8 +: 8] <= push_wdata_i[b*8 +: 8];
          r_mem_strb[w_last_ptr][b]        <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_wstrb  <= '0;
      r_busy   <= 1'b0;
    end else begin
      if (w_alloc) r_wr_ptr <= r_wr_ptr + DEPTH_W'(1);
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + DEPTH_W'(1);
        r_addr   <= r_mem_addr[r_rd_ptr];
        r_wdata  <= r_mem_data[r_rd_ptr];
        r_wstrb  <= r_mem_strb[r_rd_ptr];
      end
      if (w_alloc && !w_pop)      r_count <= r_count + (DEPTH_W+1)'(1);
      else if (w_pop && !w_alloc) r_count <= r_count - (DEPTH_W+1)'(1);
      // ready without a pop means the channel finished or is idle
      if (w_pop)        r_busy <= 1'b1;
      else if (ready_i) r_busy <= 1'b0;
    end
  end

  assign full_o  = w_full;
  assign level_o = r_count;
  assign empty_o = (r_count == '0) & ~r_busy;
  assign addr_o  = r_addr;
  assign wdata_o = r_wdata;
  assign wstrb_o = r_wstrb;
endmodule

// File: tb/tb_iob_cache_write_buffer.sv
// Directed bench for iob_cache_write_buffer: ordering, full/ignore, wrap, reset, merge behaviour.
`timescale 1ns/1ps
module tb_iob_cache_write_buffer;
  localparam int AW = 22;

  logic          clk = 1'b0;
  logic          reset_i;
  logic          push_i;
  logic [AW-1:0] push_addr_i;
  logic [31:0]   push_wdata_i;
  logic [3:0]    push_wstrb_i;
  logic          full_o, empty_o, valid_o, ready_i;
  logic [2:0]    level_o;
  logic [AW-1:0] addr_o;
  logic [31:0]   wdata_o;
  logic [3:0]    wstrb_o;

  int checks = 0;
  int errors = 0;

  iob_cache_write_buffer dut (
    .clk_i(clk), .reset_i(reset_i),
    .push_i(push_i), .push_addr_i(push_addr_i),
    .push_wdata_i(push_wdata_i), .push_wstrb_i(push_wstrb_i),
    .full_o(full_o), .empty_o(empty_o), .level_o(level_o),
    .valid_o(valid_o), .ready_i(ready_i),
    .addr_o(addr_o), .wdata_o(wdata_o), .wstrb_o(wstrb_o)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_push(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s);
    push_i       = 1'b1;
    push_addr_i  = a;
    push_wdata_i = d;
    push_wstrb_i = s;
  endtask

  initial begin
    reset_i = 1'b1; push_i = 1'b0; push_addr_i = '0; push_wdata_i = '0;
    push_wstrb_i = '0; ready_i = 1'b0;
    tick; tick;
    reset_i = 1'b0;
    check("rst_level", level_o, 0);
    check("rst_valid", valid_o, 0);
    check("rst_full",  full_o,  0);
    check("rst_empty", empty_o, 1);
    check("rst_addr",  addr_o,  0);
    check("rst_wdata", wdata_o, 0);
    check("rst_wstrb", wstrb_o, 0);

    // single push, immediate pop
    drive_push(22'h10, 32'hDEADBEEF, 4'hF);
    ready_i = 1'b1;
    tick;
    push_i = 1'b0;
    check("t1_valid", valid_o, 1);
    check("t1_level", level_o, 1);
    tick;
    check("t1_addr",  addr_o,  22'h10);
    check("t1_wdata", wdata_o, 32'hDEADBEEF);
    check("t1_wstrb", wstrb_o, 4'hF);
    check("t1_valid_lo", valid_o, 0);
    check("t1_busy_empty", empty_o, 0);
    tick;
    check("t1_empty_after", empty_o, 1);

    // fill to full, overflow push lost, drain in order
    ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_push(22'h100 + i, 32'h11110000 + i, 4'(i + 1));
      tick;
    end
    check("t2_full",  full_o,  1);
    check("t2_level", level_o, 4);
    drive_push(22'h99, 32'h99999999, 4'hF);
    tick;
    push_i = 1'b0;
    check("t2_level_ovf", level_o, 4);
    ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick;
      check("t2_addr",  addr_o,  22'h100 + i);
      check("t2_wdata", wdata_o, 32'h11110000 + i);
      check("t2_wstrb", wstrb_o, i + 1);
    end
    check("t2_level_end", level_o, 0);
    check("t2_valid_end", valid_o, 0);

    // full with simultaneous push and pop
    ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_push(22'h200 + i, 32'h22220000 + i, 4'hF);
      tick;
    end
    drive_push(22'h204, 32'h22220004, 4'hF);
    ready_i = 1'b1;
    tick;
    push_i = 1'b0;
    check("t3_level", level_o, 4);
    check("t3_full",  full_o,  1);
    check("t3_addr",  addr_o,  22'h200);
    for (int i = 1; i < 5; i++) begin
      tick;
      check("t3_addr_drain",  addr_o,  22'h200 + i);
      check("t3_wdata_drain", wdata_o, 32'h22220000 + i);
    end
    check("t3_level_end", level_o, 0);

    // interleaved push/pop across pointer wrap
    ready_i = 1'b0;
    drive_push(22'h300, 32'h33330000, 4'h3);
    tick;
    ready_i = 1'b1;
    for (int i = 1; i < 6; i++) begin
      drive_push(22'h300 + i, 32'h33330000 + i, 4'h3);
      tick;
      check("t4_addr",  addr_o,  22'h300 + i - 1);
      check("t4_wdata", wdata_o, 32'h33330000 + i - 1);
      check("t4_level", level_o, 1);
    end
    push_i = 1'b0;
    tick;
    check("t4_addr_last", addr_o, 22'h305);
    check("t4_level_end", level_o, 0);

    // reset mid-operation
    ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_push(22'h400 + i, 32'h44440000 + i, 4'hF);
      tick;
    end
    push_i = 1'b0;
    check("t5_level_pre", level_o, 3);
    reset_i = 1'b1;
    tick;
    reset_i = 1'b0;
    check("t5_level", level_o, 0);
    check("t5_valid", valid_o, 0);
    check("t5_addr",  addr_o,  0);
    check("t5_empty", empty_o, 1);

    // same-address pushes: merge or separate allocation
    drive_push(22'h20, 32'h000000AA, 4'h1);
    tick;
    drive_push(22'h20, 32'hBB000000, 4'h8);
    tick;
    push_i = 1'b0;
`ifdef IOB_CACHE_WBUF_MERGE_EN
    check("t6_level", level_o, 1);
`else
    check("t6_level", level_o, 2);
`endif
    ready_i = 1'b1;
    tick;
    check("t6_addr", addr_o, 22'h20);
`ifdef IOB_CACHE_WBUF_MERGE_EN
    check("t6_wdata", wdata_o, 32'hBB0000AA);
    check("t6_wstrb", wstrb_o, 4'h9);
`else
    check("t6_wdata", wdata_o, 32'h000000AA);
    check("t6_wstrb", wstrb_o, 4'h1);
    tick;
    check("t6_wdata2", wdata_o, 32'hBB000000);
    check("t6_wstrb2", wstrb_o, 4'h8);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
